mem_access_stage: RTL and testbench

- Pipeline MEM stage of the MIPS core. Sits between the EX/MEM request and the data memory, and drives the memory's address, data, enable, write and byte controls.
- Captures the memory's combinational read data. Sign- or zero-extends byte loads. Presents a registered MEM/WB result with a valid/ready handshake toward write-back.
- Detects misaligned and out-of-range accesses and suppresses them before they reach memory.

---
 rtl/mem_pkg.sv | 56 +++++
 rtl/load_extend.sv | 27 ++
 rtl/mem_access_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings, result record and op helpers for the MEM stage
//
// Contents:
//   OP_*               request op encodings (6 and 7 decode as NOP)
//   fault_cause_e      fault cause reported with a result
//   state_e            MEM stage control states
//   wb_result_t        one write-back result (data, rd, we, fault, cause)
//   MEM_DEPTH_DEFAULT  highest valid byte address of the data memory
package mem_pkg;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LW  = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_SW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;

    localparam int unsigned MEM_DEPTH_DEFAULT = 32'd1000000;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_RANGE    = 2'd2
    } fault_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        fault;
        logic [1:0]  cause;
    } wb_result_t;

    function automatic logic is_word_op(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_byte_op(input logic [2:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    endfunction

    function automatic logic is_load_op(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_store_op(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - load data select and byte sign/zero extension
//
// Ports:
//   op        latched request op
//   word_in   big-endian word read from memory
//   byte_in   byte read from memory
//   data_out  register-file value for the load (0 for non-loads)
module load_extend
    import mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] word_in,
    input  logic [7:0]  byte_in,
    output logic [31:0] data_out
);

    always_comb begin
        data_out = 32'd0;
        case (op)
            OP_LW:   data_out = word_in;
            OP_LB:   data_out = {{24{byte_in[7]}}, byte_in};
            OP_LBU:  data_out = {24'd0, byte_in};
            default: data_out = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS MEM pipeline stage with fault checks and skid-buffered write-back
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   i_valid/o_ready              EX/MEM request handshake
//   i_op, i_addr, i_wdata, i_rd  request op, byte address, store data, load destination
//   w_addr_32 .. w_byte_op       data memory controls, driven during the ACCESS cycle
//   w_data_out_32, w_data_out_8  combinational memory read data
//   o_wb_valid/i_wb_ready        MEM/WB result handshake
//   o_wb_data .. o_fault_cause   registered result toward write-back
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter int          ADDR_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_op,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [4:0]        i_rd,
    output logic [ADDR_W-1:0] w_addr_32,
    output logic [31:0]       w_data_in_32,
    output logic              w_write_op,
    output logic              w_en,
    output logic              w_byte_op,
    input  logic [31:0]       w_data_out_32,
    input  logic [7:0]        w_data_out_8,
    output logic              o_wb_valid,
    input  logic              i_wb_ready,
    output logic [31:0]       o_wb_data,
    output logic [4:0]        o_wb_rd,
    output logic              o_wb_we,
    output logic              o_wb_fault,
    output logic [1:0]        o_fault_cause
);

    state_e            state;
    state_e            state_next;

    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;

    wb_result_t        wb_q;
    logic              wb_valid_q;
    wb_result_t        skid_q;
    logic              skid_valid_q;

    logic              accept;
    logic              hold_next;
    logic              req_active;
    logic              misaligned;
    logic              out_of_range;
    logic              fault;
    fault_cause_e      cause;
    logic [31:0]       load_data;
    wb_result_t        access_result;

    // One extra bit so addr+3 near the top of the address space cannot wrap
    // back into the valid range.
    logic [ADDR_W:0]   addr_ext;
    logic [ADDR_W:0]   word_last;
    logic [ADDR_W:0]   depth_ext;

    assign hold_next = wb_valid_q && !i_wb_ready;
    assign accept    = i_valid && o_ready;

    // ---------------------------------------------------------------
    // Fault checks on the latched request
    // ---------------------------------------------------------------
    assign req_active = is_word_op(req_op) || is_byte_op(req_op);
    assign addr_ext   = {1'b0, req_addr};
    assign word_last  = addr_ext + (ADDR_W+1)'(3);
    assign depth_ext  = (ADDR_W+1)'(MEM_DEPTH);

    always_comb begin
        misaligned   = is_word_op(req_op) && (req_addr[1:0] != 2'b00);
        out_of_range = 1'b0;
        if (is_word_op(req_op)) begin
            out_of_range = word_last > depth_ext;
        end else if (is_byte_op(req_op)) begin
            out_of_range = addr_ext > depth_ext;
        end
        fault = misaligned || out_of_range;
        if (misaligned) begin
            cause = CAUSE_MISALIGN;
        end else if (out_of_range) begin
            cause = CAUSE_RANGE;
        end else begin
            cause = CAUSE_NONE;
        end
    end

    load_extend u_load_extend (
        .op       (req_op),
        .word_in  (w_data_out_32),
        .byte_in  (w_data_out_8),
        .data_out (load_data)
    );

    // Result produced by the current ACCESS cycle; feeds both the output
    // register and the skid register.
    always_comb begin
        access_result.data  = (fault || !is_load_op(req_op)) ? 32'd0 : load_data;
        access_result.rd    = req_rd;
        access_result.we    = is_load_op(req_op) && !fault;
        access_result.fault = fault;
        access_result.cause = cause;
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (hold_next) begin
                    state_next = ST_HOLD;
                end else if (accept) begin
                    state_next = ST_ACCESS;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (i_wb_ready) state_next = accept ? ST_ACCESS : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        o_ready      = (state == ST_IDLE)
                    || ((state == ST_ACCESS) && !hold_next)
                    || ((state == ST_HOLD) && i_wb_ready);
        w_addr_32    = req_addr;
        w_data_in_32 = req_wdata;
        w_byte_op    = is_byte_op(req_op);
        // Reset gates the strobe so an aborted store never commits.
        w_en         = (state == ST_ACCESS) && !reset && req_active && !fault;
        w_write_op   = w_en && is_store_op(req_op);
    end

    // ---------------------------------------------------------------
    // Request registers
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            req_op    <= OP_NOP;
            req_addr  <= '0;
            req_wdata <= 32'd0;
            req_rd    <= 5'd0;
        end else if (accept) begin
            req_op    <= i_op;
            req_addr  <= i_addr;
            req_wdata <= i_wdata;
            req_rd    <= i_rd;
        end
    end

    // ---------------------------------------------------------------
    // Result and skid registers
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_valid_q   <= 1'b0;
            wb_q         <= '0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_ACCESS: begin
                    if (hold_next) begin
                        // Output slot still occupied: park this result.
                        skid_q       <= access_result;
                        skid_valid_q <= req_active;
                    end else if (req_active) begin
                        wb_valid_q <= 1'b1;
                        wb_q       <= access_result;
                    end else begin
                        wb_valid_q  <= 1'b0;
                        wb_q.we     <= 1'b0;
                        wb_q.fault  <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (i_wb_ready) begin
                        if (skid_valid_q) begin
                            wb_valid_q <= 1'b1;
                            wb_q       <= skid_q;
                        end else begin
                            wb_valid_q <= 1'b0;
                            wb_q.we    <= 1'b0;
                            wb_q.fault <= 1'b0;
                        end
                        skid_valid_q <= 1'b0;
                    end
                end
                default: begin
                    if (wb_valid_q && i_wb_ready) begin
                        wb_valid_q <= 1'b0;
                        wb_q.we    <= 1'b0;
                        wb_q.fault <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_wb_valid    = wb_valid_q;
    assign o_wb_data     = wb_q.data;
    assign o_wb_rd       = wb_q.rd;
    assign o_wb_we       = wb_q.we;
    assign o_wb_fault    = wb_q.fault;
    assign o_fault_cause = wb_q.cause;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

    localparam longint unsigned DEPTH = 1000000;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_op;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [4:0]  i_rd;
    logic [31:0] w_addr_32;
    logic [31:0] w_data_in_32;
    logic        w_write_op;
    logic        w_en;
    logic        w_byte_op;
    logic [31:0] w_data_out_32;
    logic [7:0]  w_data_out_8;
    logic        o_wb_valid;
    logic        i_wb_ready;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_rd;
    logic        o_wb_we;
    logic        o_wb_fault;
    logic [1:0]  o_fault_cause;

    int tests_run    = 0;
    int tests_failed = 0;
    int wen_count    = 0;

    always #5 clock = ~clock;

    mem_access_stage #(.MEM_DEPTH(1000000), .ADDR_W(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_op          (i_op),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .i_rd          (i_rd),
        .w_addr_32     (w_addr_32),
        .w_data_in_32  (w_data_in_32),
        .w_write_op    (w_write_op),
        .w_en          (w_en),
        .w_byte_op     (w_byte_op),
        .w_data_out_32 (w_data_out_32),
        .w_data_out_8  (w_data_out_8),
        .o_wb_valid    (o_wb_valid),
        .i_wb_ready    (i_wb_ready),
        .o_wb_data     (o_wb_data),
        .o_wb_rd       (o_wb_rd),
        .o_wb_we       (o_wb_we),
        .o_wb_fault    (o_wb_fault),
        .o_fault_cause (o_fault_cause)
    );

    // Data memory attached to the DUT, and the model's own view of memory.
    bit [7:0] dmem    [int unsigned];
    bit [7:0] ref_mem [int unsigned];

    function automatic bit [7:0] dm(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : 8'h00;
    endfunction

    function automatic bit [7:0] rm(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // Read data is refreshed mid-cycle from the latched address, so it is
    // settled (and reflects stores committed on the previous edge) before
    // the edge that ends ACCESS.
    always @(negedge clock) begin
        w_data_out_8  = dm(w_addr_32);
        w_data_out_32 = {dm(w_addr_32), dm(w_addr_32 + 32'd1),
                         dm(w_addr_32 + 32'd2), dm(w_addr_32 + 32'd3)};
    end

    always @(posedge clock) begin
        if (w_en) wen_count++;
        if (w_en && w_write_op) begin
            if (w_byte_op) begin
                dmem[w_addr_32] = w_data_in_32[7:0];
            end else begin
                dmem[w_addr_32]         = w_data_in_32[31:24];
                dmem[w_addr_32 + 32'd1] = w_data_in_32[23:16];
                dmem[w_addr_32 + 32'd2] = w_data_in_32[15:8];
                dmem[w_addr_32 + 32'd3] = w_data_in_32[7:0];
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        fault;
        logic [1:0]  cause;
    } exp_t;

    exp_t exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Architectural result of one request; successful stores update the
    // model memory in program order.
    function automatic exp_t predict(input logic [2:0] op, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [4:0] rd);
        exp_t e;
        longint unsigned a = addr;
        bit word  = (op == 3'd1) || (op == 3'd4);
        bit bytex = (op == 3'd2) || (op == 3'd3) || (op == 3'd5);
        e.data = 0; e.rd = rd; e.we = 0; e.fault = 0; e.cause = 0;
        if (word && (a % 4 != 0)) begin
            e.fault = 1; e.cause = 1;
        end else if ((word && a + 3 > DEPTH) || (bytex && a > DEPTH)) begin
            e.fault = 1; e.cause = 2;
        end else begin
            case (op)
                3'd1: begin
                    e.data = {rm(addr), rm(addr + 1), rm(addr + 2), rm(addr + 3)};
                    e.we = 1;
                end
                3'd2: begin
                    e.data = (rm(addr) >= 128) ? (32'hFFFFFF00 + rm(addr)) : {24'd0, rm(addr)};
                    e.we = 1;
                end
                3'd3: begin
                    e.data = {24'd0, rm(addr)};
                    e.we = 1;
                end
                3'd4: begin
                    ref_mem[addr]     = wdata[31:24];
                    ref_mem[addr + 1] = wdata[23:16];
                    ref_mem[addr + 2] = wdata[15:8];
                    ref_mem[addr + 3] = wdata[7:0];
                end
                default: ref_mem[addr] = wdata[7:0];
            endcase
        end
        return e;
    endfunction

    // One clock: drive inputs just after a falling edge, compare any
    // presented result against the model queue, then wait for the next
    // falling edge.
    task automatic step(input bit v, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input bit wbr, output bit acc);
        exp_t e;
        i_valid = v; i_op = op; i_addr = addr; i_wdata = wdata; i_rd = rd;
        i_wb_ready = wbr;
        #1;
        acc = i_valid && o_ready;
        if (o_wb_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q[0];
                check_eq("wb_data",  o_wb_data,     e.data);
                check_eq("wb_rd",    o_wb_rd,       e.rd);
                check_eq("wb_we",    o_wb_we,       e.we);
                check_eq("wb_fault", o_wb_fault,    e.fault);
                check_eq("wb_cause", o_fault_cause, e.cause);
                if (i_wb_ready) void'(exp_q.pop_front());
            end
        end
        if (acc && op >= 3'd1 && op <= 3'd5) exp_q.push_back(predict(op, addr, wdata, rd));
        @(negedge clock);
    endtask

    task automatic idle(input bit wbr);
        bit a;
        step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, wbr, a);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) idle(1'b1);
        idle(1'b1);
        check_eq(tag, exp_q.size(), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_valid"}, o_wb_valid, 32'd0);
        check_eq({tag, "_data"},  o_wb_data, 32'd0);
        check_eq({tag, "_rd"},    o_wb_rd, 32'd0);
        check_eq({tag, "_we"},    o_wb_we, 32'd0);
        check_eq({tag, "_fault"}, o_wb_fault, 32'd0);
        check_eq({tag, "_cause"}, o_fault_cause, 32'd0);
        check_eq({tag, "_ready"}, o_ready, 32'd1);
        check_eq({tag, "_wen"},   w_en, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a1, a2, a3;
        int wen0, nbad;
        logic [2:0]  tbl_op   [3] = '{3'd1, 3'd2, 3'd3};
        logic [31:0] tbl_data [3] = '{32'h807F1234, 32'hFFFFFF80, 32'h00000080};
        logic [31:0] rand_addr;
        logic [31:0] word40;

        reset = 1'b1; i_valid = 0; i_op = 0; i_addr = 0; i_wdata = 0; i_rd = 0;
        i_wb_ready = 1'b1;
        w_data_out_32 = 0; w_data_out_8 = 0;
        dmem[32'h10] = 8'h80; dmem[32'h11] = 8'h7F; dmem[32'h12] = 8'h12; dmem[32'h13] = 8'h34;
        ref_mem[32'h10] = 8'h80; ref_mem[32'h11] = 8'h7F; ref_mem[32'h12] = 8'h12; ref_mem[32'h13] = 8'h34;
        for (int k = 0; k < 4; k++) begin
            dmem[32'h40 + k] = 8'hA5;
            ref_mem[32'h40 + k] = 8'hA5;
        end
        repeat (3) @(negedge clock);
        #1;
        check_cleared("reset");
        reset = 1'b0;
        @(negedge clock);

        // Loads of a preloaded word: latency and byte extension.
        for (int t = 0; t < 3; t++) begin
            step(1'b1, tbl_op[t], 32'h10, 32'd0, 5'd3, 1'b1, a1);
            check_eq("ld_accept", a1, 32'd1);
            check_eq("ld_valid_n1", o_wb_valid, 32'd0);
            idle(1'b1);
            check_eq("ld_valid_n2", o_wb_valid, 32'd1);
            check_eq("ld_data_const", o_wb_data, tbl_data[t]);
            check_eq("ld_we_const", o_wb_we, 32'd1);
            idle(1'b1);
        end
        drain("ld_drain");

        // Store then byte load on consecutive cycles.
        step(1'b1, 3'd4, 32'h20, 32'hDEADBEEF, 5'd0, 1'b1, a1);
        step(1'b1, 3'd2, 32'h23, 32'd0, 5'd7, 1'b1, a2);
        check_eq("b2b_accept_sw", a1, 32'd1);
        check_eq("b2b_accept_lb", a2, 32'd1);
        check_eq("b2b_ready_mid", o_ready, 32'd1);
        idle(1'b1);
        check_eq("b2b_ready_end", o_ready, 32'd1);
        check_eq("b2b_lb_data", o_wb_data, 32'hFFFFFFEF);
        drain("b2b_drain");

        // Misaligned store never reaches memory.
        wen0 = wen_count;
        step(1'b1, 3'd4, 32'h22, 32'h01020304, 5'd0, 1'b1, a1);
        idle(1'b1);
        check_eq("mis_fault", o_wb_fault, 32'd1);
        check_eq("mis_cause", o_fault_cause, 32'd1);
        check_eq("mis_we", o_wb_we, 32'd0);
        drain("mis_drain");
        check_eq("mis_no_wen", wen_count - wen0, 32'd0);
        check_eq("mis_mem", {dm(32'h20), dm(32'h21), dm(32'h22), dm(32'h23)}, 32'hDEADBEEF);

        // Range boundary.
        step(1'b1, 3'd1, 32'd999997, 32'd0, 5'd1, 1'b1, a1);
        step(1'b1, 3'd1, 32'd999998, 32'd0, 5'd2, 1'b1, a1);
        step(1'b1, 3'd5, 32'd1000000, 32'h0000005A, 5'd0, 1'b1, a1);
        step(1'b1, 3'd1, 32'hFFFFFFFC, 32'd0, 5'd4, 1'b1, a1);
        idle(1'b1);
        check_eq("rng_wrap_cause", o_fault_cause, 32'd2);
        step(1'b1, 3'd3, 32'd1000000, 32'd0, 5'd5, 1'b1, a1);
        drain("rng_drain");
        check_eq("rng_sb_mem", dm(32'd1000000), 32'h5A);

        // Backpressure: first result held, second parked, then both drain.
        step(1'b1, 3'd1, 32'h10, 32'd0, 5'd8, 1'b0, a1);
        step(1'b1, 3'd3, 32'h11, 32'd0, 5'd9, 1'b0, a2);
        step(1'b1, 3'd1, 32'h14, 32'd0, 5'd10, 1'b0, a3);
        check_eq("bp_accept_b", a2, 32'd1);
        check_eq("bp_block", a3, 32'd0);
        check_eq("bp_ready_hold", o_ready, 32'd0);
        idle(1'b0);
        check_eq("bp_held_data", o_wb_data, 32'h807F1234);
        check_eq("bp_ready_hold2", o_ready, 32'd0);
        idle(1'b1);
        check_eq("bp_second_valid", o_wb_valid, 32'd1);
        check_eq("bp_second_data", o_wb_data, 32'h0000007F);
        idle(1'b1);
        check_eq("bp_drained", exp_q.size(), 32'd0);
        drain("bp_drain");

        // Reset during ACCESS aborts the store.
        wen0 = wen_count;
        i_valid = 1'b1; i_op = 3'd4; i_addr = 32'h40; i_wdata = 32'h11223344; i_rd = 0;
        i_wb_ready = 1'b1;
        #1;
        check_eq("rst_accept", o_ready, 32'd1);
        @(negedge clock);
        i_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_cleared("rst_mid");
        word40 = {dm(32'h40), dm(32'h41), dm(32'h42), dm(32'h43)};
        check_eq("rst_mem", word40, 32'hA5A5A5A5);
        check_eq("rst_no_wen", wen_count - wen0, 32'd0);
        @(negedge clock);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0:       rand_addr = 32'(DEPTH) - 32'd5 + $urandom_range(0, 7);
                1:       rand_addr = 32'hFFFFFFF8 + $urandom_range(0, 7);
                default: rand_addr = 32'h100 + $urandom_range(0, 63);
            endcase
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rand_addr,
                 $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0, a1);
        end
        drain("rand_drain");
        nbad = 0;
        for (int k = 0; k < 64; k++)
            if (dm(32'h100 + k) != rm(32'h100 + k)) nbad++;
        for (int k = -8; k < 8; k++)
            if (dm(32'(DEPTH) + 32'(k)) != rm(32'(DEPTH) + 32'(k))) nbad++;
        for (int k = 0; k < 80; k++)
            if (dm(32'(k)) != rm(32'(k))) nbad++;
        check_eq("rand_mem", nbad, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
